// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: button debounce, start/stop/lap/clear FSM and 8-digit display scan.
// Optional STOPWATCH_AUTOSTOP_EN: force STOP when the live time reaches 59:59.99.
module stopwatch_ctrl #(
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned SCAN_DIV    = 2
) (
   input  logic        clk_1khz,
   input  logic        rst_n,
   input  logic        btn_start,
   input  logic        btn_lap,
   input  logic [31:0] time_in,
   output logic        timer_run,
   output logic        timer_clr,
   output logic        lap_hold,
   output logic [7:0]  disp_sel,
   output logic [3:0]  disp_nibble
);

   // state | meaning
   // IDLE  | cleared, timer stopped
   // RUN   | timer counting, live time shown
   // LAP   | timer counting, lap snapshot shown
   // STOP  | timer paused, live time shown
   typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

   localparam logic [7:0]  DEB_TC  = 8'(DEBOUNCE_MS);
   localparam logic [3:0]  SCAN_TC = 4'(SCAN_DIV - 1);
   localparam logic [31:0] LIMIT   = 32'h59E59E99;

   logic [1:0]       btn_raw;
   logic [1:0]       sync1, sync2, deb, deb_d, press;
   logic [1:0][7:0]  cnt;

   state_t      state, state_nxt;
   logic        capture, clr_nxt, auto_stop;
   logic [31:0] lap_reg;
   logic [31:0] disp_src;

   logic [2:0]  idx;
   logic [3:0]  div;

   assign btn_raw = {btn_lap, btn_start};

   // Bit 0 is start, bit 1 is lap; press is a registered rising edge of the debounced level.
   always_ff @(posedge clk_1khz) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         press <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb & ~deb_d;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_TC) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

`ifdef STOPWATCH_AUTOSTOP_EN
   assign auto_stop = ((state == RUN) || (state == LAP)) && (time_in == LIMIT);
`else
   assign auto_stop = 1'b0;
`endif

   // Start is tested first, so a simultaneous lap press is dropped.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      clr_nxt   = 1'b0;
      if (auto_stop) begin
         state_nxt = STOP;
      end else begin
         case (state)
            IDLE: if (press[0]) state_nxt = RUN;
            RUN: begin
               if (press[0]) begin
                  state_nxt = STOP;
               end else if (press[1]) begin
                  state_nxt = LAP;
                  capture   = 1'b1;
               end
            end
            LAP: begin
               if (press[0])      state_nxt = STOP;
               else if (press[1]) state_nxt = RUN;
            end
            STOP: begin
               if (press[0]) begin
                  state_nxt = RUN;
               end else if (press[1]) begin
                  state_nxt = IDLE;
                  clr_nxt   = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_1khz) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer_run <= 1'b0;
         timer_clr <= 1'b0;
         lap_hold  <= 1'b0;
         lap_reg   <= '0;
      end else begin
         state     <= state_nxt;
         timer_run <= (state_nxt == RUN) || (state_nxt == LAP);
         lap_hold  <= (state_nxt == LAP);
         timer_clr <= clr_nxt;
         if (capture) lap_reg <= time_in;
      end
   end

   assign disp_src = lap_hold ? lap_reg : time_in;

   // Digit select and its nibble are loaded together once per scan slot.
   always_ff @(posedge clk_1khz) begin
      if (!rst_n) begin
         idx         <= '0;
         div         <= '0;
         disp_sel    <= 8'hFF;
         disp_nibble <= 4'h0;
      end else if (div == SCAN_TC) begin
         div         <= '0;
         idx         <= idx + 3'd1;
         disp_sel    <= ~(8'd1 << idx);
         disp_nibble <= disp_src[{idx, 2'b00} +: 4];
      end else begin
         div <= div + 4'd1;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues timed expectations, a monitor checks them.
module tb_stopwatch_ctrl;

   localparam int DEB  = 4;
   localparam int SDIV = 2;

   localparam int S_RUN = 0, S_CLR = 1, S_LAP = 2, S_SEL = 3, S_NIB = 4;

   logic        clk_1khz = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_start = 1'b0;
   logic        btn_lap = 1'b0;
   logic [31:0] time_in = 32'h76543210;
   logic        timer_run, timer_clr, lap_hold;
   logic [7:0]  disp_sel;
   logic [3:0]  disp_nibble;

   stopwatch_ctrl #(.DEBOUNCE_MS(DEB), .SCAN_DIV(SDIV)) dut (
      .clk_1khz   (clk_1khz),
      .rst_n      (rst_n),
      .btn_start  (btn_start),
      .btn_lap    (btn_lap),
      .time_in    (time_in),
      .timer_run  (timer_run),
      .timer_clr  (timer_clr),
      .lap_hold   (lap_hold),
      .disp_sel   (disp_sel),
      .disp_nibble(disp_nibble)
   );

   always #5 clk_1khz = ~clk_1khz;

   int cyc = 0;
   always @(posedge clk_1khz) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          r_rel = 0;
   logic [31:0] mon_act;
   logic [3:0]  lap_digits [8] = '{4'h6, 4'h5, 4'hE, 4'h4, 4'h3, 4'hE, 4'h2, 4'h1};

   task automatic expect_at(input int c, input int s, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc = c; e.sig = s; e.val = v; e.name = nm;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] actual(input int s);
      case (s)
         S_RUN:   return {31'd0, timer_run};
         S_CLR:   return {31'd0, timer_clr};
         S_LAP:   return {31'd0, lap_hold};
         S_SEL:   return {24'd0, disp_sel};
         default: return {28'd0, disp_nibble};
      endcase
   endfunction

   function automatic int digit_at(input int c);
      return ((c - r_rel - 2) / SDIV) % 8;
   endfunction

   always @(negedge clk_1khz) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            n_vec++;
            mon_act = actual(sb[i].sig);
            if (sb[i].cyc < cyc) begin
               n_bad++;
               $display("FAIL %s: due at cycle %0d, seen late at %0d", sb[i].name, sb[i].cyc, cyc);
            end else if (mon_act !== sb[i].val) begin
               n_bad++;
               $display("FAIL %s @cycle %0d: got %h, want %h", sb[i].name, cyc, mon_act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic press(input logic s, input logic l);
      btn_start = s;
      btn_lap   = l;
      repeat (10) @(negedge clk_1khz);
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      repeat (10) @(negedge clk_1khz);
   endtask

   initial begin
      int          n;
      int          k;
      logic [31:0] tv;

      repeat (3) @(negedge clk_1khz);
      n = cyc;
      expect_at(n + 1, S_RUN, 0, "reset_run");
      expect_at(n + 1, S_CLR, 0, "reset_clr");
      expect_at(n + 1, S_LAP, 0, "reset_lap");
      expect_at(n + 1, S_SEL, 32'hFF, "reset_sel");
      expect_at(n + 1, S_NIB, 0, "reset_nib");
      @(negedge clk_1khz);
      rst_n = 1'b1;
      r_rel = cyc;

      tv = time_in;
      for (int c = r_rel + 1; c <= r_rel + 21; c++) begin
         if (c < r_rel + 2) begin
            expect_at(c, S_SEL, 32'hFF, "scan_sel_pre");
         end else begin
            k = digit_at(c);
            expect_at(c, S_SEL, {24'd0, ~(8'd1 << k)}, "scan_sel");
            expect_at(c, S_NIB, {28'd0, tv[k*4 +: 4]}, "scan_nib");
         end
      end
      repeat (21) @(negedge clk_1khz);
      rst_n = 1'b0;
      expect_at(cyc + 1, S_SEL, 32'hFF, "midscan_rst_sel");
      expect_at(cyc + 1, S_NIB, 0, "midscan_rst_nib");
      @(negedge clk_1khz);
      rst_n = 1'b1;
      r_rel = cyc;
      expect_at(r_rel + 1, S_SEL, 32'hFF, "rescan_sel_pre");
      expect_at(r_rel + 2, S_SEL, 32'hFE, "rescan_sel_first");

      n = cyc;
      btn_start = 1'b1;
      repeat (3) @(negedge clk_1khz);
      btn_start = 1'b0;
      expect_at(n + 10, S_RUN, 0, "glitch_run_a");
      expect_at(n + 15, S_RUN, 0, "glitch_run_b");
      repeat (17) @(negedge clk_1khz);

      n = cyc;
      expect_at(n + 8, S_RUN, 0, "start_run_before");
      expect_at(n + 9, S_RUN, 1, "start_run_after");
      expect_at(n + 9, S_LAP, 0, "start_lap");
      press(1'b1, 1'b0);

      time_in = 32'h12E34E56;
      n = cyc;
      expect_at(n + 8, S_LAP, 0, "lap_hold_before");
      expect_at(n + 9, S_LAP, 1, "lap_hold_after");
      expect_at(n + 9, S_RUN, 1, "lap_run");
      btn_lap = 1'b1;
      repeat (10) @(negedge clk_1khz);
      btn_lap = 1'b0;
      repeat (2) @(negedge clk_1khz);
      time_in = 32'hABCDEF01;
      for (int c = n + 14; c <= n + 29; c++)
         expect_at(c, S_NIB, {28'd0, lap_digits[digit_at(c)]}, "lap_nib");
      repeat (18) @(negedge clk_1khz);

      n = cyc;
      expect_at(n + 9, S_LAP, 0, "unlap_hold");
      expect_at(n + 9, S_RUN, 1, "unlap_run");
      tv = time_in;
      for (int c = n + 12; c <= n + 15; c++) begin
         k = digit_at(c);
         expect_at(c, S_NIB, {28'd0, tv[k*4 +: 4]}, "live_nib");
      end
      press(1'b0, 1'b1);

      n = cyc;
      expect_at(n + 9, S_RUN, 0, "both_run");
      expect_at(n + 9, S_LAP, 0, "both_lap");
      expect_at(n + 9, S_CLR, 0, "both_clr");
      press(1'b1, 1'b1);

      n = cyc;
      expect_at(n + 9, S_RUN, 1, "resume_run");
      press(1'b1, 1'b0);

      n = cyc;
      expect_at(n + 9, S_RUN, 0, "stop_run");
      press(1'b1, 1'b0);

      n = cyc;
      expect_at(n + 8, S_CLR, 0, "clr_before");
      expect_at(n + 9, S_CLR, 1, "clr_pulse");
      expect_at(n + 10, S_CLR, 0, "clr_after");
      expect_at(n + 9, S_RUN, 0, "clr_run");
      press(1'b0, 1'b1);

      n = cyc;
      expect_at(n + 8, S_CLR, 0, "idle_lap_clr_a");
      expect_at(n + 9, S_CLR, 0, "idle_lap_clr_b");
      expect_at(n + 10, S_CLR, 0, "idle_lap_clr_c");
      expect_at(n + 9, S_LAP, 0, "idle_lap_hold");
      expect_at(n + 9, S_RUN, 0, "idle_lap_run");
      press(1'b0, 1'b1);

      n = cyc;
      expect_at(n + 9, S_RUN, 1, "restart_run");
      press(1'b1, 1'b0);

      n = cyc;
      time_in = 32'h59E59E99;
`ifdef STOPWATCH_AUTOSTOP_EN
      expect_at(n + 1, S_RUN, 0, "limit_run_a");
      expect_at(n + 3, S_RUN, 0, "limit_run_b");
`else
      expect_at(n + 1, S_RUN, 1, "limit_run_a");
      expect_at(n + 3, S_RUN, 1, "limit_run_b");
`endif
      expect_at(n + 3, S_LAP, 0, "limit_lap");
      repeat (4) @(negedge clk_1khz);

      for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk_1khz);
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d checks pending, want 0", sb.size());
         n_vec += sb.size();
         n_bad += sb.size();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
